data_ram_sp: RTL and testbench

- Parametrised single-port synchronous data memory for the CPU's load/store path; next generation of the 8-bit asynchronous data RAM.
- Replaces the bidirectional data bus with separate write/read buses, per-byte write enables and a registered read with a valid strobe.
- Adds a hardware clear sequence after reset, so memory contents are defined before the first access.
- Sits between the ALU address output and the write-back mux.

---
 rtl/data_ram_sp.sv | 106 ++++++++++
 tb/tb_data_ram_sp.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_sp.sv
// Single-port synchronous data RAM with a post-reset clear sweep, byte-lane writes and a registered read.
// Optional DATA_RAM_PARITY_EN: stores one even-parity bit per byte lane and flags mismatches on read.
module data_ram_sp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                ready,
    output logic                err
);

    localparam int unsigned       NB   = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                in_range;
    logic                par_bad;

    // Widened compare so the DEPTH == 2**ADDR_W case stays in range.
    always_comb begin
        in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    end

`ifdef DATA_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];

    always_comb begin
        par_bad = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if ((^mem[addr][8*i +: 8]) != par[addr][i]) par_bad = 1'b1;
        end
    end
`else
    always_comb begin
        par_bad = 1'b0;
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            ready  <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                S_CLEAR: begin
                    mem[cnt] <= '0;
`ifdef DATA_RAM_PARITY_EN
                    par[cnt] <= '0;
`endif
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        if (!in_range) begin
                            err <= 1'b1;
                            if (!we) begin
                                rdata  <= '0;
                                rvalid <= 1'b1;
                            end
                        end else if (we) begin
                            for (int unsigned i = 0; i < NB; i++) begin
                                if (be[i]) begin
                                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef DATA_RAM_PARITY_EN
                                    par[addr][i] <= ^wdata[8*i +: 8];
`endif
                                end
                            end
                        end else begin
                            rdata  <= mem[addr];
                            rvalid <= 1'b1;
                            if (par_bad) err <= 1'b1;
                        end
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_sp.sv
// Directed and randomized checks of data_ram_sp against an array-based reference model.
module tb_data_ram_sp;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req, we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid, ready, err;

    logic        req2, we2;
    logic [7:0]  addr2;
    logic [3:0]  be2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        rvalid2, ready2, err2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [256];
    logic [31:0] exp_rdata;

    always #5 CLK = ~CLK;

    data_ram_sp dut (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .be(be),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .ready(ready), .err(err)
    );

    data_ram_sp #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) dut2 (
        .CLK(CLK), .RST(RST), .req(req2), .we(we2), .addr(addr2), .be(be2),
        .wdata(wdata2), .rdata(rdata2), .rvalid(rvalid2), .ready(ready2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] mask = 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) mask = mask | (32'hFF << (8 * i));
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        exp_rdata = 32'h0;
    endtask

    // One main-DUT bus cycle, checked against the reference model.
    task automatic cycle(input logic r, input logic w, input logic [7:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req = r; we = w; addr = a; be = b; wdata = d;
        step();
        req = 1'b0;
        if (r && !w) exp_rdata = model[a];
        if (r && w)  model[a] = merge(model[a], d, b);
        check("rvalid", rvalid, r && !w);
        check("rdata", rdata, exp_rdata);
        check("err", err, 1'b0);
        check("ready", ready, 1'b1);
    endtask

    task automatic cycle2(input logic w, input logic [7:0] a, input logic [31:0] d);
        req2 = 1'b1; we2 = w; addr2 = a; be2 = 4'hF; wdata2 = d;
        step();
        req2 = 1'b0;
    endtask

    // Counts cycles after reset release until ready; optionally pokes requests meanwhile.
    task automatic wait_ready(input bit poke, output int n);
        n = 0;
        while (!ready && n < 400) begin
            if (poke && n >= 60) begin
                req = 1'b1; we = 1'($urandom); addr = 8'h33; be = 4'hF; wdata = $urandom;
            end
            step();
            n++;
            if (poke) check("clear_rvalid", rvalid, 1'b0);
            if (n == 199 || n == 200) check("ready2_rise", ready2, n == 200);
        end
        req = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] r;
        RST = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; be2 = '0; wdata2 = '0;

        step();
        step();
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready2", ready2, 1'b0);

        RST = 1'b1;
        wait_ready(1'b1, n);
        check("clear_len", n, 256);
        model_clear();

        cycle(1'b1, 1'b0, 8'h00, 4'h0, 32'h0);
        check("rd00", rdata, 32'h0);
        cycle(1'b1, 1'b0, 8'h7F, 4'h0, 32'h0);
        check("rd7f", rdata, 32'h0);
        cycle(1'b1, 1'b0, 8'hFF, 4'h0, 32'h0);
        check("rdff", rdata, 32'h0);
        cycle(1'b1, 1'b0, 8'h33, 4'h0, 32'h0);
        check("no_clear_write", rdata, 32'h0);

        cycle(1'b1, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
        check("deadbeef", rdata, 32'hDEADBEEF);
        cycle(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        cycle(1'b1, 1'b1, 8'h10, 4'b0101, 32'h11223344);
        cycle(1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
        check("partial_be", rdata, 32'hDE22BE44);
        cycle(1'b1, 1'b1, 8'h10, 4'h0, 32'hFFFFFFFF);
        cycle(1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
        check("be_zero", rdata, 32'hDE22BE44);

        cycle(1'b1, 1'b1, 8'h01, 4'hF, 32'hA);
        cycle(1'b1, 1'b1, 8'h02, 4'hF, 32'hB);
        cycle(1'b1, 1'b1, 8'h03, 4'hF, 32'hC);
        cycle(1'b1, 1'b0, 8'h01, 4'h0, 32'h0);
        check("b2b_a", rdata, 32'hA);
        cycle(1'b1, 1'b0, 8'h02, 4'h0, 32'h0);
        check("b2b_b", rdata, 32'hB);
        cycle(1'b1, 1'b0, 8'h03, 4'h0, 32'h0);
        check("b2b_c", rdata, 32'hC);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            cycle(r[0] | r[1], r[2], r[3] ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
                  4'($urandom), $urandom);
        end

`ifdef DATA_RAM_PARITY_EN
        cycle(1'b1, 1'b1, 8'h05, 4'hF, 32'h12345678);
        dut.mem[5] = dut.mem[5] ^ 32'h1;
        req = 1'b1; we = 1'b0; addr = 8'h05;
        step();
        req = 1'b0;
        check("par_rvalid", rvalid, 1'b1);
        check("par_err", err, 1'b1);
        check("par_rdata", rdata, 32'h12345679);
`endif

        // Reset coincident with a read: the read must not produce rvalid.
        req = 1'b1; we = 1'b0; addr = 8'h10; RST = 1'b0;
        step();
        req = 1'b0;
        check("rst_cancel_rvalid", rvalid, 1'b0);
        check("rst_err_clear", err, 1'b0);
        step();
        RST = 1'b1;
        repeat (100) step();
        check("mid_clear_ready", ready, 1'b0);
        RST = 1'b0;
        step();
        RST = 1'b1;
        wait_ready(1'b0, n);
        check("restart_clear_len", n, 256);
        model_clear();
        cycle(1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
        check("recleared", rdata, 32'h0);

        cycle2(1'b1, 8'h20, 32'h5A5A5A5A);
        cycle2(1'b0, 8'h20, 32'h0);
        check("d2_inrange_rdata", rdata2, 32'h5A5A5A5A);
        check("d2_inrange_err", err2, 1'b0);
        cycle2(1'b0, 8'hF0, 32'h0);
        check("d2_oor_rdata", rdata2, 32'h0);
        check("d2_oor_rvalid", rvalid2, 1'b1);
        check("d2_oor_err", err2, 1'b1);
        repeat (5) step();
        check("d2_err_sticky", err2, 1'b1);
        check("d2_rvalid_idle", rvalid2, 1'b0);

        RST = 1'b0;
        step();
        step();
        check("d2_err_reset", err2, 1'b0);
        RST = 1'b1;
        wait_ready(1'b0, n);
        cycle2(1'b1, 8'hC8, 32'hFFFFFFFF);
        check("d2_oor_wr_err", err2, 1'b1);
        check("d2_oor_wr_rvalid", rvalid2, 1'b0);
        cycle2(1'b0, 8'hC7, 32'h0);
        check("d2_last_word", rdata2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
